// File: rtl/wb_commit.sv
// Writeback/commit stage: fixed-priority LSU/EXU arbitration, 1-cycle registered regfile write,
// per-register busy scoreboard, retired count. Optional forwarding of the pending write via WB_BYPASS_EN.
module wb_commit #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_exu_valid,
   output logic                  o_exu_ready,
   input  logic                  i_exu_wen,
   input  logic [ADDR_WIDTH-1:0] i_exu_rd,
   input  logic [DATA_WIDTH-1:0] i_exu_data,
   input  logic                  i_lsu_valid,
   output logic                  o_lsu_ready,
   input  logic                  i_lsu_wen,
   input  logic [ADDR_WIDTH-1:0] i_lsu_rd,
   input  logic [DATA_WIDTH-1:0] i_lsu_data,
   input  logic                  i_issue_valid,
   input  logic [ADDR_WIDTH-1:0] i_issue_rd,
   input  logic [ADDR_WIDTH-1:0] i_qaddr1,
   output logic                  o_qbusy1,
   input  logic [ADDR_WIDTH-1:0] i_qaddr2,
   output logic                  o_qbusy2,
   output logic                  o_rf_wen,
   output logic [ADDR_WIDTH-1:0] o_rf_waddr,
   output logic [DATA_WIDTH-1:0] o_rf_wdata,
   output logic                  o_commit_valid,
   output logic [63:0]           o_commit_cnt
`ifdef WB_BYPASS_EN
   ,
   output logic                  o_qfwd1,
   output logic [DATA_WIDTH-1:0] o_qfwd_data1,
   output logic                  o_qfwd2,
   output logic [DATA_WIDTH-1:0] o_qfwd_data2
`endif
);

   localparam int NREG = 2 ** ADDR_WIDTH;

   typedef struct packed {
      logic                  wen;
      logic [ADDR_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0] data;
   } res_t;

   res_t                  w_sel;
   logic                  w_grant;
   logic [NREG-1:0]       w_busy_nxt;
   logic [NREG-1:0]       r_busy;
   logic                  r_rf_wen;
   logic [ADDR_WIDTH-1:0] r_rf_waddr;
   logic [DATA_WIDTH-1:0] r_rf_wdata;
   logic                  r_commit_valid;
   logic [63:0]           r_commit_cnt;

   assign o_lsu_ready = 1'b1;
   assign o_exu_ready = ~i_lsu_valid;
   assign w_grant     = i_lsu_valid | i_exu_valid;

   always_comb begin
      if (i_lsu_valid) begin
         w_sel = '{wen: i_lsu_wen, rd: i_lsu_rd, data: i_lsu_data};
      end else begin
         w_sel = '{wen: i_exu_wen, rd: i_exu_rd, data: i_exu_data};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rf_wen       <= 1'b0;
         r_rf_waddr     <= '0;
         r_rf_wdata     <= '0;
         r_commit_valid <= 1'b0;
         r_commit_cnt   <= '0;
      end else begin
         r_rf_wen       <= w_grant & w_sel.wen & (w_sel.rd != '0);
         r_commit_valid <= w_grant;
         if (w_grant) begin
            r_rf_waddr   <= w_sel.rd;
            r_rf_wdata   <= w_sel.data;
            r_commit_cnt <= r_commit_cnt + 64'd1;
         end
      end
   end

   // Clear applied before set so a new producer on the clearing edge keeps the bit busy.
   always_comb begin
      w_busy_nxt = r_busy;
      if (r_rf_wen) begin
         w_busy_nxt[r_rf_waddr] = 1'b0;
      end
      if (i_issue_valid && (i_issue_rd != '0)) begin
         w_busy_nxt[i_issue_rd] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   assign o_rf_wen       = r_rf_wen;
   assign o_rf_waddr     = r_rf_waddr;
   assign o_rf_wdata     = r_rf_wdata;
   assign o_commit_valid = r_commit_valid;
   assign o_commit_cnt   = r_commit_cnt;

`ifdef WB_BYPASS_EN
   logic w_fwd1;
   logic w_fwd2;

   assign w_fwd1       = r_rf_wen & (r_rf_waddr == i_qaddr1) & (i_qaddr1 != '0);
   assign w_fwd2       = r_rf_wen & (r_rf_waddr == i_qaddr2) & (i_qaddr2 != '0);
   assign o_qfwd1      = w_fwd1;
   assign o_qfwd2      = w_fwd2;
   assign o_qfwd_data1 = w_fwd1 ? r_rf_wdata : '0;
   assign o_qfwd_data2 = w_fwd2 ? r_rf_wdata : '0;
   assign o_qbusy1     = r_busy[i_qaddr1] & ~w_fwd1;
   assign o_qbusy2     = r_busy[i_qaddr2] & ~w_fwd2;
`else
   assign o_qbusy1 = r_busy[i_qaddr1];
   assign o_qbusy2 = r_busy[i_qaddr2];
`endif

endmodule
